// File: rtl/disparity_pkg.sv
`default_nettype none
// ============================================================================
// Package  : disparity_pkg
// Purpose  : Shared state encoding, defaults and accumulator sizing for the
//            disparity search controller.
// Revision : 1.0
// ============================================================================
package disparity_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int c_WIN_PIXELS = 6;
  localparam int c_MAX_DISP   = 16;
  localparam int c_ADDR_W     = 10;

  // Worst-case SSD: every pixel differs by the full 8-bit range.
  function automatic int acc_width(input int win_pixels);
    return $clog2(255 * 255 * win_pixels) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/disparity_argmin.sv
`default_nettype none
// ============================================================================
// Module   : disparity_argmin
// Purpose  : Running minimum of sampled costs; strict compare keeps the lowest
//            disparity on ties. DISP_CONF_EN adds the second-lowest cost.
// Revision : 1.0
// ============================================================================
module disparity_argmin
  import disparity_pkg::*;
#(
  parameter int ACC_W  = acc_width(c_WIN_PIXELS),
  parameter int DISP_W = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              init_in,
  input  logic              sample_in,
  input  logic [ACC_W-1:0]  cost_in,
  input  logic [DISP_W-1:0] disp_in,
`ifdef DISP_CONF_EN
  output logic [ACC_W-1:0]  second_cost_out,
`endif
  output logic [ACC_W-1:0]  best_cost_out,
  output logic [DISP_W-1:0] best_disp_out
);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      best_cost_out   <= '1;
      best_disp_out   <= '0;
`ifdef DISP_CONF_EN
      second_cost_out <= '1;
`endif
    end else if (init_in) begin
      best_cost_out   <= '1;
      best_disp_out   <= '0;
`ifdef DISP_CONF_EN
      second_cost_out <= '1;
`endif
    end else if (sample_in) begin
      if (cost_in < best_cost_out) begin
        best_cost_out   <= cost_in;
        best_disp_out   <= disp_in;
`ifdef DISP_CONF_EN
        second_cost_out <= best_cost_out;
`endif
      end
`ifdef DISP_CONF_EN
      // A tie with best lands here too and becomes the second cost.
      else if (cost_in <= second_cost_out) begin
        second_cost_out <= cost_in;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/disparity_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disparity_search_ctrl
// Purpose  : Sequences the shared SSD MAC engine over all candidate
//            disparities of one window and returns the minimum-cost result.
// Options  : DISP_CONF_EN adds second_cost_out (second-lowest cost).
// Revision : 1.0
// ============================================================================
module disparity_search_ctrl
  import disparity_pkg::*;
#(
  parameter int WIN_PIXELS = c_WIN_PIXELS,
  parameter int MAX_DISP   = c_MAX_DISP,
  parameter int ADDR_W     = c_ADDR_W,
  parameter int ACC_W      = acc_width(WIN_PIXELS)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  output logic                        start_ready_out,
  input  logic [ADDR_W-1:0]           base_addr_in,
  output logic                        rd_en_out,
  output logic [ADDR_W-1:0]           left_addr_out,
  output logic [ADDR_W-1:0]           right_addr_out,
  output logic                        mac_valid_out,
  output logic                        mac_clr_out,
  input  logic [ACC_W-1:0]            mac_acc_in,
  output logic                        result_valid_out,
  input  logic                        result_ready_in,
  output logic [$clog2(MAX_DISP)-1:0] disp_out,
  output logic [ACC_W-1:0]            cost_out,
`ifdef DISP_CONF_EN
  output logic [ACC_W-1:0]            second_cost_out,
`endif
  output logic                        busy_out
);

  localparam int DISP_W = $clog2(MAX_DISP);
  localparam int K_W    = (WIN_PIXELS > 1) ? $clog2(WIN_PIXELS) : 1;
  localparam logic [K_W-1:0]    c_K_LAST = K_W'(WIN_PIXELS - 1);
  localparam logic [DISP_W-1:0] c_D_LAST = DISP_W'(MAX_DISP - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [DISP_W-1:0] r_d;
  logic [K_W-1:0]    r_k;
  logic [ACC_W-1:0]  w_best_cost;
  logic [DISP_W-1:0] w_best_disp;
  logic [ADDR_W-1:0] w_next_off;
  logic              w_init;
  logic              w_sample;
  logic              w_last_disp;
`ifdef DISP_CONF_EN
  logic [ACC_W-1:0]  w_second_cost;
`endif

  assign w_init     = (r_state == IDLE) && start_in && start_ready_out;
  assign w_sample   = (r_state == COMPARE);
  assign w_next_off = ADDR_W'(r_k) + ADDR_W'(1);
  // Stop once d+1 would exceed base, keeping base+k-d non-negative.
  assign w_last_disp = (r_d == c_D_LAST) ||
                       ({1'b0, r_base} < ((ADDR_W+1)'(r_d) + (ADDR_W+1)'(1)));

  disparity_argmin #(
    .ACC_W  (ACC_W),
    .DISP_W (DISP_W)
  ) u_argmin (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .init_in         (w_init),
    .sample_in       (w_sample),
    .cost_in         (mac_acc_in),
    .disp_in         (r_d),
`ifdef DISP_CONF_EN
    .second_cost_out (w_second_cost),
`endif
    .best_cost_out   (w_best_cost),
    .best_disp_out   (w_best_disp)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state          <= IDLE;
      r_base           <= '0;
      r_d              <= '0;
      r_k              <= '0;
      start_ready_out  <= 1'b0;
      rd_en_out        <= 1'b0;
      left_addr_out    <= '0;
      right_addr_out   <= '0;
      mac_valid_out    <= 1'b0;
      mac_clr_out      <= 1'b0;
      result_valid_out <= 1'b0;
      disp_out         <= '0;
      cost_out         <= '0;
`ifdef DISP_CONF_EN
      second_cost_out  <= '1;
`endif
      busy_out         <= 1'b0;
    end else begin
      mac_valid_out <= rd_en_out;
      mac_clr_out   <= 1'b0;
      case (r_state)
        IDLE: begin
          start_ready_out <= 1'b1;
          if (w_init) begin
            r_base          <= base_addr_in;
            r_d             <= '0;
            start_ready_out <= 1'b0;
            busy_out        <= 1'b1;
            mac_clr_out     <= 1'b1;
            r_state         <= CLEAR;
          end
        end
        CLEAR: begin
          r_k            <= '0;
          rd_en_out      <= 1'b1;
          left_addr_out  <= r_base;
          right_addr_out <= r_base - ADDR_W'(r_d);
          r_state        <= FEED;
        end
        FEED: begin
          if (r_k == c_K_LAST) begin
            rd_en_out <= 1'b0;
            r_state   <= DRAIN;
          end else begin
            r_k            <= r_k + K_W'(1);
            left_addr_out  <= r_base + w_next_off;
            right_addr_out <= r_base + w_next_off - ADDR_W'(r_d);
          end
        end
        DRAIN: begin
          r_state <= COMPARE;
        end
        COMPARE: begin
          if (w_last_disp) begin
            r_state <= DONE;
          end else begin
            r_d         <= r_d + DISP_W'(1);
            mac_clr_out <= 1'b1;
            r_state     <= CLEAR;
          end
        end
        DONE: begin
          // First cycle captures the argmin, which settles at the final COMPARE edge.
          if (!result_valid_out) begin
            result_valid_out <= 1'b1;
            disp_out         <= w_best_disp;
            cost_out         <= w_best_cost;
`ifdef DISP_CONF_EN
            second_cost_out  <= w_second_cost;
`endif
          end else if (result_ready_in) begin
            result_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            start_ready_out  <= 1'b1;
            r_state          <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disparity_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_disparity_search_ctrl
// Purpose  : Self-checking bench: SSD MAC engine and line-buffer models around
//            the controller, results compared with a behavioural search model.
// Revision : 1.0
// ============================================================================
module tb_disparity_search_ctrl;

  localparam int WIN = 6;
  localparam int MD  = 4;
  localparam int AW  = 10;
  localparam int ACC = 20;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           start_in;
  logic           start_ready_out;
  logic [AW-1:0]  base_addr_in;
  logic           rd_en_out;
  logic [AW-1:0]  left_addr_out;
  logic [AW-1:0]  right_addr_out;
  logic           mac_valid_out;
  logic           mac_clr_out;
  logic [ACC-1:0] mac_acc_in;
  logic           result_valid_out;
  logic           result_ready_in;
  logic [1:0]     disp_out;
  logic [ACC-1:0] cost_out;
`ifdef DISP_CONF_EN
  logic [ACC-1:0] second_cost_out;
`endif
  logic           busy_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  disparity_search_ctrl #(
    .WIN_PIXELS (WIN),
    .MAX_DISP   (MD),
    .ADDR_W     (AW),
    .ACC_W      (ACC)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .start_ready_out  (start_ready_out),
    .base_addr_in     (base_addr_in),
    .rd_en_out        (rd_en_out),
    .left_addr_out    (left_addr_out),
    .right_addr_out   (right_addr_out),
    .mac_valid_out    (mac_valid_out),
    .mac_clr_out      (mac_clr_out),
    .mac_acc_in       (mac_acc_in),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .disp_out         (disp_out),
    .cost_out         (cost_out),
`ifdef DISP_CONF_EN
    .second_cost_out  (second_cost_out),
`endif
    .busy_out         (busy_out)
  );

  // Line buffers (1-cycle read) and SSD MAC engine.
  logic [7:0]     lmem [0:1023];
  logic [7:0]     rmem [0:1023];
  logic [7:0]     l_q, r_q;
  logic [ACC-1:0] eng_acc;

  always @(posedge clk_in) begin
    if (rd_en_out) begin
      l_q <= lmem[left_addr_out];
      r_q <= rmem[right_addr_out];
    end
    if (mac_clr_out) eng_acc <= '0;
    else if (mac_valid_out)
      eng_acc <= eng_acc + ACC'((int'(l_q) - int'(r_q)) * (int'(l_q) - int'(r_q)));
  end

  // Optional cost table replaces the engine to force exact per-disparity costs.
  bit use_tbl = 1'b0;
  int cost_tbl [0:MD-1];
  int clr_cnt = 0;
  int clr_base = 0;
  int tbl_idx;

  always @(posedge clk_in) if (mac_clr_out) clr_cnt <= clr_cnt + 1;

  always_comb begin
    mac_acc_in = eng_acc;
    tbl_idx    = clr_cnt - clr_base - 1;
    if (use_tbl && tbl_idx >= 0 && tbl_idx < MD) mac_acc_in = ACC'(cost_tbl[tbl_idx]);
  end

  int rd_total = 0;
  int bad_total = 0;
  always @(negedge clk_in) begin
    if (rd_en_out) begin
      rd_total <= rd_total + 1;
      if (right_addr_out > left_addr_out) bad_total <= bad_total + 1;
    end
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int window_ssd(input int base, input int d);
    int s = 0;
    for (int k = 0; k < WIN; k++) begin
      int df;
      df = int'(lmem[base + k]) - int'(rmem[base + k - d]);
      s += df * df;
    end
    return s;
  endfunction

  // Search defined directly: candidates 0..min(MD-1, base), strict minimum.
  function automatic void ref_search(input int base, output int ed, output int ec,
                                     output int es, output int nev);
    int c;
    ed = 0; ec = (1 << ACC) - 1; es = ec; nev = 0;
    for (int d = 0; d < MD; d++) begin
      if (d > base) break;
      c = use_tbl ? cost_tbl[d] : window_ssd(base, d);
      nev++;
      if (c < ec) begin es = ec; ec = c; ed = d; end
      else if (c <= es) es = c;
    end
  endfunction

  task automatic run_search(input string tag, input int base, input int hold);
    int ed, ec, es, nev, cyc, rd0, bad0, n;
    ref_search(base, ed, ec, es, nev);
    @(negedge clk_in);
    n = 0;
    while (!start_ready_out && n < 20) begin @(negedge clk_in); n++; end
    chk({tag, "_start_ready"}, start_ready_out, 1);
    clr_base = clr_cnt;
    rd0 = rd_total; bad0 = bad_total;
    base_addr_in = AW'(base);
    start_in = 1'b1;
    @(posedge clk_in); #1 start_in = 1'b0;
    cyc = 0;
    while (!result_valid_out && cyc < 200) begin @(posedge clk_in); #1; cyc++; end
    chk({tag, "_valid"}, result_valid_out, 1);
    chk({tag, "_latency"}, cyc, nev * (WIN + 3) + 1);
    chk({tag, "_disp"}, disp_out, ed);
    chk({tag, "_cost"}, cost_out, ec);
`ifdef DISP_CONF_EN
    chk({tag, "_second"}, second_cost_out, es);
`endif
    chk({tag, "_rd_cycles"}, rd_total - rd0, nev * WIN);
    chk({tag, "_addr_wrap"}, bad_total - bad0, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_in);
      start_in = (i == 1);
      chk({tag, "_bp_valid"}, result_valid_out, 1);
      chk({tag, "_bp_disp"}, disp_out, ed);
      chk({tag, "_bp_cost"}, cost_out, ec);
      chk({tag, "_bp_start_ready"}, start_ready_out, 0);
    end
    @(negedge clk_in);
    start_in = 1'b0;
    result_ready_in = 1'b1;
    @(posedge clk_in); #1;
    chk({tag, "_hs_valid"}, result_valid_out, 0);
    chk({tag, "_hs_busy"}, busy_out, 0);
    chk({tag, "_hs_start_ready"}, start_ready_out, 1);
    @(negedge clk_in);
    result_ready_in = 1'b0;
    @(posedge clk_in); #1;
    chk({tag, "_idle_stays"}, busy_out, 0);
  endtask

  task automatic load_min_at_2();
    for (int i = 0; i < 1024; i++) begin lmem[i] = 8'd100; rmem[i] = 8'd90; end
    for (int i = 8; i <= 13; i++) rmem[i] = 8'd100;
  endtask

  initial begin
    rst_in = 1'b0; start_in = 1'b0; result_ready_in = 1'b0; base_addr_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_start_ready", start_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_rd_en", rd_en_out, 0);
    chk("rst_mac_clr", mac_clr_out, 0);
    chk("rst_mac_valid", mac_valid_out, 0);
    chk("rst_result_valid", result_valid_out, 0);
    chk("rst_disp", disp_out, 0);
    chk("rst_cost", cost_out, 0);
`ifdef DISP_CONF_EN
    chk("rst_second", second_cost_out, (1 << ACC) - 1);
`endif
    @(negedge clk_in) rst_in = 1'b1;

    load_min_at_2();
    run_search("min_d2", 10, 0);

    for (int i = 0; i < 1024; i++) begin lmem[i] = 8'd100; rmem[i] = 8'd90; end
    run_search("ties", 10, 0);

    for (int i = 0; i < 64; i++) begin
      lmem[i] = 8'($urandom_range(0, 255)); rmem[i] = 8'($urandom_range(0, 255));
    end
    run_search("clamp", 1, 0);

    load_min_at_2();
    run_search("backpressure", 10, 5);

    // Reset during FEED of d=1.
    @(negedge clk_in);
    base_addr_in = AW'(10);
    start_in = 1'b1;
    @(posedge clk_in); #1 start_in = 1'b0;
    repeat (12) @(posedge clk_in);
    #1;
    chk("midrst_in_feed", rd_en_out, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("midrst_rd_en", rd_en_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_mac_valid", mac_valid_out, 0);
    chk("midrst_mac_clr", mac_clr_out, 0);
    chk("midrst_left", left_addr_out, 0);
    chk("midrst_right", right_addr_out, 0);
    chk("midrst_result_valid", result_valid_out, 0);
    @(negedge clk_in) rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("postrst_busy", busy_out, 0);
    chk("postrst_start_ready", start_ready_out, 1);
    run_search("after_rst", 10, 0);

    use_tbl = 1'b1;
    cost_tbl = '{500, 300, 300, 800};
    run_search("conf_tbl", 10, 1);
    use_tbl = 1'b0;

    for (int it = 0; it < 10; it++) begin
      bit narrow;
      narrow = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 64; i++) begin
        lmem[i] = narrow ? 8'($urandom_range(98, 102)) : 8'($urandom_range(0, 255));
        rmem[i] = narrow ? 8'($urandom_range(98, 102)) : 8'($urandom_range(0, 255));
      end
      run_search("rand", $urandom_range(0, 30), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
